lam_rong_xung: RTL and testbench
================================

// Module: lam_rong_xung
// PURPOSE
//  Pulse widener: the counterpart of the one-cycle pulse narrower.
//  - Detects a rising edge on input d.
//  - Drives q high for exactly WIDTH clocks, then enforces GAP low clocks before the next trigger is accepted.
//  - Makes short strobes (button, edge-detector output) visible to LEDs or slower logic.
//  - Counts triggers it had to drop.
// PARAMETERS
//  WIDTH  4  q high time in clocks; legal 1..255
//  GAP    2  minimum q low time after a stretch, in clocks; legal 0..255
// PORTS
//  ckht      in   1  system clock; all logic on the rising edge
//  rst       in   1  synchronous, active-high reset
//  d         in   1  trigger input, level or pulse, synchronous to ckht
//  q         out  1  stretched pulse, registered
//  busy      out  1  high in STRETCH or GAP
//  drop_cnt  out  8  saturating count of rejected triggers
// BEHAVIOUR
//  - Reset, while rst=1 at a clock edge:
//    - q=0, busy=0, drop_cnt=0, state=IDLE, counter=0.
//    - d_prev=1, so d held high through reset does not trigger. d must fall, then rise.
//  - Trigger: trig = d & ~d_prev, evaluated every edge. d_prev <= d every edge outside reset.
//  - Registered counter, 8 bits. State machine:
//    - IDLE:
//      - trig -> STRETCH, cnt=WIDTH-1, q=1 from that edge.
//      - Latency: d rises before edge N, q=1 after edge N.
//    - STRETCH:
//      - cnt>0: cnt-1, q stays 1.
//      - cnt==0 and GAP>0: -> GAP, cnt=GAP-1, q=0.
//      - cnt==0 and GAP==0: -> IDLE, q=0.
//      - q is therefore high for exactly WIDTH edges.
//    - GAP:
//      - cnt>0: cnt-1.
//      - cnt==0: -> IDLE.
//      - q=0 for exactly GAP edges.
//      - A trig on the edge that leaves GAP is still a GAP trigger (dropped).
//  - busy = (state != IDLE), registered together with state.
//  - Trigger in GAP: dropped; drop_cnt+1.
//  - Trigger in STRETCH, including its final cycle: handled per CONFIGURATION.
//  - drop_cnt saturates at 255. It never wraps and is cleared only by rst.
//  - rst mid-stretch: q falls on that same edge, and all state returns to reset values.
//  - WIDTH=1, GAP=0: q is a one-cycle pulse. Back-to-back triggers need d low for at least 1 cycle, because of edge detection.
// CONFIGURATION
//  - RETRIGGER_EN defined:
//    - trig in STRETCH reloads cnt=WIDTH-1. q stays high continuously.
//    - The stretch ends WIDTH edges after the latest trigger.
//    - drop_cnt is unchanged.
//  - RETRIGGER_EN undefined:
//    - trig in STRETCH is ignored and drop_cnt+1.
//    - The stretch length is unaffected.
//  - GAP behaviour is identical in both builds.
// TESTING
//  1. rst=1 for 3 edges with d=1, release rst with d=1 -> q=0, busy=0, drop_cnt=0. No trigger until d falls and rises.
//  2. WIDTH=4, GAP=2, single d rise at edge 10 -> q=1 after edges 10..13, q=0 from edge 14; busy=1 through edge 15; IDLE at edge 16.
//  3. WIDTH=4, second d rise at edge 12:
//     - RETRIGGER_EN undefined -> q low from edge 14, drop_cnt=1.
//     - RETRIGGER_EN defined -> q high through edge 15, drop_cnt=0.
//  4. d rise during GAP (edge 15 in scenario 2) -> ignored, drop_cnt=1. Next rise at edge 18 -> new 4-cycle stretch.
//  5. 300 triggers, all landing in GAP -> drop_cnt holds 255, no wrap.
//  6. rst asserted at edge 12 of scenario 2 -> q=0 and busy=0 after edge 12. Next rise gives a full 4-cycle stretch.
//  Run 2-4 for WIDTH=1, GAP=0 and for WIDTH=255, GAP=255. Check q width against the parameters with a cycle-counting scoreboard.

Source files
------------

// File: rtl/lam_rong_xung.sv
`default_nettype none
// ============================================================================
//  Module      : lam_rong_xung
//  Description : Pulse widener. A rising edge on d drives q high for exactly
//                WIDTH clocks, followed by at least GAP low clocks before a
//                new trigger is accepted. Rejected triggers are counted in a
//                saturating 8-bit counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     q high time in clocks, 1..255
//    GAP       minimum q low time after a stretch, in clocks, 0..255
//  Ports
//    ckht      in   1  system clock, rising edge
//    rst       in   1  synchronous active-high reset
//    d         in   1  trigger input (level or pulse), synchronous to ckht
//    q         out  1  stretched pulse, registered
//    busy      out  1  high while stretching or enforcing the gap
//    drop_cnt  out  8  saturating count of rejected triggers
//  Build option
//    RETRIGGER_EN  when defined, a trigger during the stretch restarts the
//                  WIDTH count; otherwise it is rejected and counted.
// ============================================================================
module lam_rong_xung #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2
) (
    input  logic       ckht,
    input  logic       rst,
    input  logic       d,
    output logic       q,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    // Counter load values: the counter runs from LOAD down to 0, so the
    // state lasts LOAD+1 edges.
    localparam logic [7:0] WIDTH_LOAD = 8'(WIDTH - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         HAS_GAP    = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       d_prev;
    logic       trig;
    logic       drop_evt;
    logic       retrig;        // trigger that restarts an active stretch
    logic       stretch_drop;  // trigger rejected during an active stretch

    // d_prev resets to 1 so a d held high through reset is not an edge.
    assign trig = d & ~d_prev;

`ifdef RETRIGGER_EN
    assign retrig       = trig;
    assign stretch_drop = 1'b0;
`else
    assign retrig       = 1'b0;
    assign stretch_drop = trig;
`endif

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_evt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt = ST_STRETCH;
                    cnt_nxt   = WIDTH_LOAD;
                end
            end

            ST_STRETCH: begin
                // The final stretch cycle (cnt==0) still counts as stretch
                // for trigger handling, so the reload check comes first.
                drop_evt = stretch_drop;
                if (retrig) begin
                    cnt_nxt = WIDTH_LOAD;
                end else if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (HAS_GAP) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end
            end

            ST_GAP: begin
                // Any trigger seen in GAP is rejected, including one on the
                // edge that returns to IDLE.
                drop_evt = trig;
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register; q and busy are registered from the next state so
    // they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge ckht) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            q        <= 1'b0;
            busy     <= 1'b0;
            d_prev   <= 1'b1;
            drop_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q      <= (state_nxt == ST_STRETCH);
            busy   <= (state_nxt != ST_IDLE);
            d_prev <= d;
            if (drop_evt && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lam_rong_xung.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lam_rong_xung
//  Description : Scoreboard bench for lam_rong_xung. Three instances
//                (WIDTH/GAP = 4/2, 1/0, 255/255) share one d/rst stimulus.
//                A time-based reference model records, per instance, the
//                edge at which q falls and the edge at which the block goes
//                idle; expectations are queued per edge and a monitor pops
//                and compares them on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lam_rong_xung;

    logic       clk;
    logic       rst;
    logic       d;
    logic [2:0] q_w;
    logic [2:0] busy_w;
    logic [7:0] drop_w [3];

    int checks = 0;
    int errors = 0;

    lam_rong_xung #(.WIDTH(4), .GAP(2)) u_dut0 (
        .ckht(clk), .rst(rst), .d(d), .q(q_w[0]), .busy(busy_w[0]), .drop_cnt(drop_w[0])
    );
    lam_rong_xung #(.WIDTH(1), .GAP(0)) u_dut1 (
        .ckht(clk), .rst(rst), .d(d), .q(q_w[1]), .busy(busy_w[1]), .drop_cnt(drop_w[1])
    );
    lam_rong_xung #(.WIDTH(255), .GAP(255)) u_dut2 (
        .ckht(clk), .rst(rst), .d(d), .q(q_w[2]), .busy(busy_w[2]), .drop_cnt(drop_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: after edge n, q=1 iff n < hi_end, busy=1 iff
    // n < idle_at. A trigger at edge n is judged by the state after n-1.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       q;
        logic       busy;
        logic [7:0] drop;
    } exp_t;

    int   mw [3] = '{4, 1, 255};
    int   mg [3] = '{2, 0, 255};
    int   hi_end [3];
    int   idle_at [3];
    int   mdrop [3];
    bit   mdprev = 1'b1;
    int   edge_n = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    task automatic model_step();
        bit   trig;
        exp_t e;
        trig   = d && !mdprev;
        edge_n = edge_n + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                hi_end[i]  = 0;
                idle_at[i] = 0;
                mdrop[i]   = 0;
            end else if (trig) begin
                if (edge_n - 1 < hi_end[i]) begin
`ifdef RETRIGGER_EN
                    hi_end[i]  = edge_n + mw[i];
                    idle_at[i] = hi_end[i] + mg[i];
`else
                    if (mdrop[i] < 255) mdrop[i] = mdrop[i] + 1;
`endif
                end else if (edge_n - 1 < idle_at[i]) begin
                    if (mdrop[i] < 255) mdrop[i] = mdrop[i] + 1;
                end else begin
                    hi_end[i]  = edge_n + mw[i];
                    idle_at[i] = hi_end[i] + mg[i];
                end
            end
            e.q    = (edge_n < hi_end[i]);
            e.busy = (edge_n < idle_at[i]);
            e.drop = 8'(mdrop[i]);
            case (i)
                0:       sb0.push_back(e);
                1:       sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
        mdprev = rst ? 1'b1 : d;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int dut, input int got, input int expv);
        checks = checks + 1;
        if (got != expv) begin
            errors = errors + 1;
            $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", name, dut, edge_n, got, expv);
        end
    endtask

    task automatic compare_dut(input int i, input exp_t e);
        chk("q", i, int'(q_w[i]), int'(e.q));
        chk("busy", i, int'(busy_w[i]), int'(e.busy));
        chk("drop_cnt", i, int'(drop_w[i]), int'(e.drop));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb0.size() > 0) begin e = sb0.pop_front(); compare_dut(0, e); end
            if (sb1.size() > 0) begin e = sb1.pop_front(); compare_dut(1, e); end
            if (sb2.size() > 0) begin e = sb2.pop_front(); compare_dut(2, e); end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic hold(input logic dv, input logic rv, input int n);
        repeat (n) begin
            @(negedge clk);
            d   = dv;
            rst = rv;
        end
    endtask

    initial begin
        d   = 1'b1;
        rst = 1'b1;
        // Reset with d high; d stays high after release: no trigger.
        hold(1, 1, 3);
        hold(1, 0, 4);
        hold(0, 0, 2);
        // Single rise with a second rise two edges later.
        hold(1, 0, 1);
        hold(0, 0, 1);
        hold(1, 0, 1);
        hold(0, 0, 12);
        // Rise, rise in the gap, rise once idle.
        hold(1, 0, 1);
        hold(0, 0, 4);
        hold(1, 0, 1);
        hold(0, 0, 2);
        hold(1, 0, 2);
        hold(0, 0, 10);
        // Reset two edges into a stretch, then a fresh stretch.
        hold(1, 0, 2);
        hold(1, 1, 1);
        hold(0, 0, 2);
        hold(1, 0, 1);
        hold(0, 0, 8);
        // Back-to-back minimal pulses.
        repeat (6) begin
            hold(1, 0, 1);
            hold(0, 0, 1);
        end
        hold(0, 0, 520);
        // Rises every 5 edges: every other one lands in the 4/2 gap, so
        // drop counters run into saturation.
        repeat (620) begin
            hold(1, 0, 1);
            hold(0, 0, 4);
        end
        // Random traffic with occasional resets.
        repeat (1500) begin
            hold(($urandom_range(0, 3) == 0) ? ~d : d,
                 ($urandom_range(0, 299) == 0), 1);
        end
        hold(0, 0, 520);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb0.size() + sb1.size() + sb2.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d queued entries expected 0",
                     sb0.size() + sb1.size() + sb2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish by 2000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
